// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks the CRC-32 FCS, drops the FCS and marks frame boundaries/errors.
// Define GMII_RX_STATS_EN to add saturating good / CRC-error / runt frame counters.
module gmii_rx_framer #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic [10:0] out_len
`ifdef GMII_RX_STATS_EN
    ,
    output logic [31:0] stat_good,
    output logic [31:0] stat_crc_err,
    output logic [31:0] stat_runt
`endif
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] LEN_MIN     = 11'(MIN_FRAME);
    localparam logic [10:0] LEN_MAX     = 11'(MAX_FRAME);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic [3:0][7:0] r_dly;
    logic [7:0]      r_hold;
    logic            r_hold_vld;
    logic            r_first;
    logic [31:0]     r_crc;
    logic [10:0]     r_count;
    logic            r_er_seen;

    logic            w_shift;
    logic            w_end;
    logic            w_crc_bad;
    logic            w_runt;
    logic            w_frame_err;

    assign w_shift     = (r_state == S_DATA) && gmii_rx_dv;
    assign w_end       = (r_state == S_DATA) && !gmii_rx_dv;
    assign w_crc_bad   = (r_crc != CRC_RESIDUE);
    assign w_runt      = (r_count < LEN_MIN);
    assign w_frame_err = w_crc_bad || r_er_seen || w_runt || (r_count > LEN_MAX);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == 8'h55)      w_next = S_PREAMBLE;
                    else if (gmii_rxd == 8'hD5) w_next = S_DATA;
                    else                        w_next = S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!gmii_rx_dv)            w_next = S_IDLE;
                else if (gmii_rxd == 8'hD5) w_next = S_DATA;
                else if (gmii_rxd != 8'h55) w_next = S_DROP;
            end
            S_DATA:  if (!gmii_rx_dv) w_next = S_IDLE;
            S_DROP:  if (!gmii_rx_dv) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The byte leaving the 4-deep FCS delay line waits one cycle in r_hold, so the
    // last payload byte can still be tagged with eof once dv is seen low.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_err    <= 1'b0;
            out_len    <= 11'd0;
            r_dly      <= '0;
            r_hold     <= 8'h00;
            r_hold_vld <= 1'b0;
            r_first    <= 1'b1;
            r_crc      <= 32'hFFFFFFFF;
            r_count    <= 11'd0;
            r_er_seen  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_err   <= 1'b0;
            out_len   <= 11'd0;
            if (w_shift) begin
                r_dly      <= {r_dly[2:0], gmii_rxd};
                r_hold     <= r_dly[3];
                r_hold_vld <= (r_count >= 11'd4);
                r_crc      <= crc_byte(r_crc, gmii_rxd);
                if (r_count != 11'd2047) r_count <= r_count + 11'd1;
                if (gmii_rx_er) r_er_seen <= 1'b1;
                if (r_hold_vld) begin
                    out_valid <= 1'b1;
                    out_data  <= r_hold;
                    out_sof   <= r_first;
                    r_first   <= 1'b0;
                end
            end else if (w_end) begin
                if (r_hold_vld) begin
                    out_valid <= 1'b1;
                    out_data  <= r_hold;
                    out_sof   <= r_first;
                    out_eof   <= 1'b1;
                    out_err   <= w_frame_err;
                    out_len   <= r_count;
                end
                r_hold_vld <= 1'b0;
                r_first    <= 1'b1;
                r_crc      <= 32'hFFFFFFFF;
                r_count    <= 11'd0;
                r_er_seen  <= 1'b0;
            end
        end
    end

`ifdef GMII_RX_STATS_EN
    logic r_pend_crc;
    logic r_pend_runt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pend_crc   <= 1'b0;
            r_pend_runt  <= 1'b0;
            stat_good    <= 32'd0;
            stat_crc_err <= 32'd0;
            stat_runt    <= 32'd0;
        end else begin
            r_pend_crc  <= w_end && w_crc_bad;
            r_pend_runt <= w_end && w_runt;
            if (out_eof && !out_err && stat_good != 32'hFFFFFFFF) stat_good <= stat_good + 32'd1;
            if (r_pend_crc && stat_crc_err != 32'hFFFFFFFF) stat_crc_err <= stat_crc_err + 32'd1;
            if (r_pend_runt && stat_runt != 32'hFFFFFFFF) stat_runt <= stat_runt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomized bench for gmii_rx_framer; expected beats come from a frame-level model (standard CRC-32 FCS check).
module tb_gmii_rx_framer;
    typedef struct packed {
        logic [7:0]  data;
        logic        sof;
        logic        eof;
        logic        err;
        logic [10:0] len;
    } beat_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid, out_sof, out_eof, out_err;
    logic [10:0] out_len;
`ifdef GMII_RX_STATS_EN
    logic [31:0] stat_good, stat_crc_err, stat_runt;
`endif

    gmii_rx_framer dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
        .out_eof(out_eof), .out_err(out_err), .out_len(out_len)
`ifdef GMII_RX_STATS_EN
        , .stat_good(stat_good), .stat_crc_err(stat_crc_err), .stat_runt(stat_runt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          sfd_cyc = 0;
    int          exp_good = 0, exp_crc = 0, exp_runt = 0;
    logic [7:0]  tx_q[$];
    beat_t       got_q[$];
    beat_t       exp_q[$];
    int          got_cyc[$];

    always @(posedge sys_clk) begin
        beat_t b;
        cyc = cyc + 1;
        #1;
        if (out_valid) begin
            b.data = out_data; b.sof = out_sof; b.eof = out_eof; b.err = out_err; b.len = out_len;
            got_q.push_back(b);
            got_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] crc32(input int m);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < m; i++) begin
            c = c ^ {24'h0, tx_q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input int plen, input bit good);
        logic [31:0] fcs;
        tx_q.delete();
        for (int i = 0; i < plen; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        fcs = crc32(plen);
        tx_q.push_back(fcs[7:0]);  tx_q.push_back(fcs[15:8]);
        tx_q.push_back(fcs[23:16]); tx_q.push_back(fcs[31:24]);
        if (!good) tx_q[plen + $urandom_range(0, 3)] ^= (8'h01 << $urandom_range(0, 7));
    endtask

    task automatic model_frame(input bit er_hit);
        int          n = tx_q.size();
        bit          crc_bad, bad;
        logic [10:0] len;
        beat_t       b;
        if (n >= 4) crc_bad = (crc32(n - 4) != {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]});
        else        crc_bad = 1'b1;
        bad = crc_bad || er_hit || n < 64 || n > 1518;
        len = (n > 2047) ? 11'd2047 : 11'(n);
        for (int i = 0; i < n - 4; i++) begin
            b.data = tx_q[i]; b.sof = (i == 0); b.eof = (i == n - 5);
            b.err = b.eof && bad; b.len = b.eof ? len : 11'd0;
            exp_q.push_back(b);
        end
        if (crc_bad) exp_crc++;
        if (n < 64) exp_runt++;
        if (n > 4 && !bad) exp_good++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic drive_frame(input int npre, input int er_at, input int rst_at);
        for (int i = 0; i < npre; i++) begin
            @(negedge sys_clk); gmii_rx_dv = 1'b1; gmii_rxd = 8'h55; gmii_rx_er = 1'b0;
        end
        @(negedge sys_clk); gmii_rx_dv = 1'b1; gmii_rxd = 8'hD5; sfd_cyc = cyc + 1;
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge sys_clk);
            gmii_rxd = tx_q[i]; gmii_rx_er = (i == er_at); sys_rst = (i == rst_at);
        end
        @(negedge sys_clk); gmii_rx_dv = 1'b0; gmii_rxd = 8'h00; gmii_rx_er = 1'b0; sys_rst = 1'b0;
    endtask

    task automatic drive_raw();
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge sys_clk); gmii_rx_dv = 1'b1; gmii_rxd = tx_q[i];
        end
        @(negedge sys_clk); gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
    endtask

    task automatic clear_q();
        got_q.delete(); exp_q.delete(); got_cyc.delete();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; gmii_rx_dv = 1'b0;
        idle(3);
        sys_rst = 1'b0;
        idle(2);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_sof !== 1'b0)   begin errors++; $display("FAIL reset_sof got=%b exp=0", out_sof); end
        checks++; if (out_eof !== 1'b0)   begin errors++; $display("FAIL reset_eof got=%b exp=0", out_eof); end
        checks++; if (out_err !== 1'b0)   begin errors++; $display("FAIL reset_err got=%b exp=0", out_err); end
        checks++; if (out_len !== 11'd0)  begin errors++; $display("FAIL reset_len got=%0d exp=0", out_len); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", out_data); end
`ifdef GMII_RX_STATS_EN
        checks++; if ({stat_good, stat_crc_err, stat_runt} !== 96'd0) begin
            errors++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", stat_good, stat_crc_err, stat_runt); end
`endif
    endtask

    task automatic test_good_frame();
        clear_q();
        build_frame(60, 1'b1);
        model_frame(1'b0);
        drive_frame(7, -1, -1);
        idle(12);
        checks++; if (got_q.size() != 60) begin errors++; $display("FAIL good_count got=%0d exp=60", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        if (got_cyc.size() > 0) begin
            checks++; if (got_cyc[0] != sfd_cyc + 6) begin errors++; $display("FAIL good_latency got=%0d exp=%0d", got_cyc[0] - sfd_cyc, 6); end
        end
    endtask

    task automatic test_fcs_error();
        clear_q();
        tx_q[63] ^= 8'h10;
        model_frame(1'b0);
        drive_frame(7, -1, -1);
        idle(12);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fcs_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fcs_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
`ifdef GMII_RX_STATS_EN
        checks++; if (stat_crc_err !== 32'(exp_crc)) begin errors++; $display("FAIL fcs_stat_crc got=%0d exp=%0d", stat_crc_err, exp_crc); end
`endif
    endtask

    task automatic test_rx_er();
        clear_q();
        build_frame(96, 1'b1);
        model_frame(1'b1);
        drive_frame(7, 40, -1);
        idle(12);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rxer_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rxer_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        build_frame(60, 1'b1); model_frame(1'b0); drive_frame(7, -1, -1);
        build_frame(60, 1'b1); model_frame(1'b0); drive_frame(7, -1, -1);
        idle(12);
        checks++; if (got_q.size() != 120) begin errors++; $display("FAIL b2b_count got=%0d exp=120", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
`ifdef GMII_RX_STATS_EN
        checks++; if (stat_good !== 32'(exp_good)) begin errors++; $display("FAIL b2b_stat_good got=%0d exp=%0d", stat_good, exp_good); end
`endif
    endtask

    task automatic test_runt_and_drop();
        clear_q();
        tx_q.delete();
        for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        model_frame(1'b0);
        drive_frame(7, -1, -1);
        idle(8);
        tx_q = '{8'h55, 8'h55, 8'hAA, 8'hD5};
        for (int i = 0; i < 70; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        drive_raw();
        idle(12);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL runt_drop_count got=%0d exp=0", got_q.size()); end
`ifdef GMII_RX_STATS_EN
        checks++; if (stat_runt !== 32'(exp_runt)) begin errors++; $display("FAIL runt_stat got=%0d exp=%0d", stat_runt, exp_runt); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        beat_t b;
        clear_q();
        build_frame(60, 1'b1);
        tx_q[21] = 8'h00;
        for (int i = 0; i < 15; i++) begin
            b.data = tx_q[i]; b.sof = (i == 0); b.eof = 1'b0; b.err = 1'b0; b.len = 11'd0;
            exp_q.push_back(b);
        end
        exp_good = 0; exp_crc = 0; exp_runt = 0;
        drive_frame(7, -1, 20);
        idle(5);
        build_frame(60, 1'b1); model_frame(1'b0); drive_frame(7, -1, -1);
        idle(12);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
`ifdef GMII_RX_STATS_EN
        checks++; if ({stat_good, stat_crc_err, stat_runt} !== {32'(exp_good), 32'(exp_crc), 32'(exp_runt)}) begin
            errors++; $display("FAIL rstmid_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", stat_good, stat_crc_err, stat_runt, exp_good, exp_crc, exp_runt); end
`endif
    endtask

    task automatic test_boundaries();
        int sizes[5] = '{63, 64, 1518, 1519, 2100};
        clear_q();
        foreach (sizes[k]) begin
            build_frame(sizes[k] - 4, 1'b1); model_frame(1'b0); drive_frame(7, -1, -1);
        end
        idle(12);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bound_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bound_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int n, er_at, npre;
        clear_q();
        for (int f = 0; f < 10; f++) begin
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(60, 140);
            if (n < 4) begin
                tx_q.delete();
                for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            end else begin
                build_frame(n - 4, $urandom_range(0, 3) != 0);
            end
            er_at = (n > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            npre = $urandom_range(0, 7);
            model_frame(er_at >= 0);
            drive_frame(npre, er_at, -1);
            idle($urandom_range(0, 2));
        end
        idle(12);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
`ifdef GMII_RX_STATS_EN
        checks++; if ({stat_good, stat_crc_err, stat_runt} !== {32'(exp_good), 32'(exp_crc), 32'(exp_runt)}) begin
            errors++; $display("FAIL rand_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", stat_good, stat_crc_err, stat_runt, exp_good, exp_crc, exp_runt); end
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_fcs_error();
        test_rx_er();
        test_back_to_back();
        test_runt_and_drop();
        test_reset_mid_frame();
        test_boundaries();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
